// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder: FSM state encodings and default width.
package serial_add_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int SERIAL_ADD_WIDTH = 8;
endpackage

// File: rtl/serial_add_fa_cell.sv
// One-bit full adder; the only arithmetic resource of the serial adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: steps one full-adder cell LSB-first, one bit per clock.
// Optional SERIAL_ADD_OVF_EN adds a signed-overflow output held with sum.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADD_WIDTH,
    localparam int CW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);
    logic [1:0]       state_q;
    logic [CW-1:0]    idx_q;
    logic [WIDTH-1:0] a_q, b_q, shreg_q, shreg_d, sum_q;
    logic             carry_q, cout_q, busy_q, done_q;
    logic             fa_s, fa_co, last_bit;

    fa_cell u_fa (
        .a   (a_q[idx_q]),
        .b   (b_q[idx_q]),
        .cin (carry_q),
        .s   (fa_s),
        .cout(fa_co)
    );

    // New sum bit enters at the MSB so bit 0 lands in place after WIDTH shifts.
    assign shreg_d  = {fa_s, shreg_q[WIDTH-1:1]};
    assign last_bit = (idx_q == CW'(WIDTH - 1));

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_q;
    // On the last bit carry_q is the carry into the MSB, fa_co the carry out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_q <= 1'b0;
        else if (state_q == ST_RUN && last_bit)
            ovf_q <= carry_q ^ fa_co;
    end
    assign ovf = ovf_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            shreg_q <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    carry_q <= fa_co;
                    shreg_q <= shreg_d;
                    idx_q   <= idx_q + 1'b1;
                    if (last_bit) begin
                        sum_q   <= shreg_d;
                        cout_q  <= fa_co;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder sequencer built around a single one-bit full-adder cell. Accepts two WIDTH-bit operands and a carry-in on a start pulse, then steps the cell LSB-first, one bit per clock. A registered carry closes the loop between cycles. Sum and carry-out are presented with a one-cycle done pulse. Used where area matters more than latency; the multi-bit add is time-shared over one full-adder resource.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 2..32
CW, $clog2(WIDTH), bit-index counter width; derived, not overridden

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request a new addition; sampled in IDLE or DONE only
a  input  WIDTH  operand A; latched on accepted start
b  input  WIDTH  operand B; latched on accepted start
cin  input  1  carry-in; latched on accepted start
busy  output  1  high while state is RUN
done  output  1  one-cycle pulse; sum/cout valid
sum  output  WIDTH  result; held stable until the next accepted start completes
cout  output  1  final carry-out; held with sum

Behaviour:
- Reset (rst_n low, async): state=IDLE, busy=0, done=0, sum=0, cout=0, bit index=0, carry reg=0, operand regs=0.
- FSM states: IDLE, RUN, DONE (2-bit encoding).
- IDLE: start=1 at edge k latches a, b, cin, clears the index, moves to RUN. start=0 stays in IDLE.
- RUN: at each edge, the cell computes A[idx]+B[idx]+carry. The sum bit shifts into the result shift register from the MSB side. The carry reg takes the cell cout. idx increments.
  - On the edge that processes idx=WIDTH-1: sum is loaded with the full result, cout with the final carry, and the state moves to DONE.
- Latency: start sampled at edge k; bits processed at edges k+1..k+WIDTH; done=1 during the cycle after edge k+WIDTH. Start to done is WIDTH+1 edges.
- DONE: done=1 for exactly one cycle.
  - start=1 at this edge: back-to-back accept, latch new operands, go to RUN.
  - Otherwise go to IDLE.
- start in RUN is ignored; no queuing.
- Operand inputs are don't-care except at the accepting edge.
- sum/cout update only at the final RUN edge; the previous result remains visible during a following RUN.
- Arithmetic is unsigned modulo 2^WIDTH; cout is bit WIDTH of a+b+cin.
- Reset asserted mid-RUN aborts immediately. No done is generated; outputs go to reset values.

Optional Feature:
SERIAL_ADD_OVF_EN
- Defined: adds output port ovf (1 bit), the two's-complement signed overflow. It equals the carry into the MSB XOR the carry out of the MSB, captured at the final RUN edge and held with sum. Reset value 0.
- Undefined: no ovf port and no associated logic; all other behaviour identical.

Decomposition:
- Package serial_add_pkg holds:
  - state localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
  - default WIDTH constant
- One sub-module fa_cell: purely combinational one-bit full adder (a, b, cin -> s, cout), instantiated once.
- FSM, index counter, shift registers and carry reg live in serial_add_ctrl.

Test Plan:
- WIDTH=8, a=8'h35, b=8'h4A, cin=0, start pulse -> done exactly 9 edges after start edge; sum=8'h7F, cout=0; busy high for 8 cycles.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- start re-pulsed with a=8'h01, b=8'h01 at RUN cycle 3 of a 8'h10+8'h20 add -> ignored; result 8'h30, cout=0, single done pulse.
- start held high through DONE with new a=8'h0F, b=8'h01 -> back-to-back accept; second done 9 edges later with sum=8'h10; the first result 8'h30 stays visible until then.
- rst_n pulled low mid-RUN (cycle 4) -> busy, done, sum and cout go to 0 asynchronously; no done after release; next start works normally.
- With SERIAL_ADD_OVF_EN: a=8'h7F, b=8'h01 -> sum=8'h80, ovf=1. a=8'h80, b=8'hFF -> sum=8'h7F, cout=1, ovf=1. a=8'hFF, b=8'h01 -> ovf=0.
